// File: rtl/fc_word_aligner_if.sv
// Fast-command aligner bus: serial bit stream and relock in, aligned words and
// lock statistics out.
interface fc_word_aligner_if;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned CMD_W  = 32;
  localparam int unsigned LOSS_W = 16;

  logic              fc_in;
  logic              relock;
  logic              locked;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_is_idle;
  logic [CMD_W-1:0]  cmd_count;
  logic [LOSS_W-1:0] lock_loss_count;

  modport master (
    output fc_in, relock,
    input  locked, word_out, word_valid, word_is_idle, cmd_count, lock_loss_count
  );

  modport slave (
    input  fc_in, relock,
    output locked, word_out, word_valid, word_is_idle, cmd_count, lock_loss_count
  );
endinterface

// File: rtl/fc_word_aligner.sv
// Aligns the serial 320 MHz fast-command stream to 8-bit words by hunting for
// the IDLE pattern; emits one aligned word per 8 clocks once locked.
module fc_word_aligner #(
  parameter logic [7:0]  IDLE_WORD  = 8'hAC,
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned MAX_GAP    = 64
) (
  input  logic               clk,
  input  logic               aresetn,
  fc_word_aligner_if.slave   fc
);
  localparam int unsigned WORD_W = 8;
  localparam int unsigned PH_W   = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CMD_W  = 32;
  localparam int unsigned LOSS_W = 16;

  localparam logic [CNT_W-1:0]  LOCK_CNT = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]  GAP_MAX  = CNT_W'(MAX_GAP);
  localparam logic [LOSS_W-1:0] LOSS_SAT = '1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [WORD_W-1:0]  sr_q, sr_nxt;
  logic [PH_W-1:0]    ph_q, ph_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [CNT_W-1:0]   gap_q, gap_nxt;
  logic               locked_q, locked_nxt;
  logic [WORD_W-1:0]  word_q, word_nxt;
  logic               word_valid_q, word_valid_nxt;
  logic               word_idle_q, word_idle_nxt;
  logic [CMD_W-1:0]   cmd_q, cmd_nxt;
  logic [LOSS_W-1:0]  loss_q, loss_nxt;

  logic               is_idle;
  logic               boundary;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   gap_inc;

  assign is_idle  = (sr_q == IDLE_WORD);
  assign boundary = (ph_q == '0);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign gap_inc  = gap_q + CNT_W'(1);

  // State and output registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_SEARCH;
      sr_q         <= '0;
      ph_q         <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      locked_q     <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      word_idle_q  <= 1'b0;
      cmd_q        <= '0;
      loss_q       <= '0;
    end else begin
      state_q      <= state_nxt;
      sr_q         <= sr_nxt;
      ph_q         <= ph_nxt;
      cnt_q        <= cnt_nxt;
      gap_q        <= gap_nxt;
      locked_q     <= locked_nxt;
      word_q       <= word_nxt;
      word_valid_q <= word_valid_nxt;
      word_idle_q  <= word_idle_nxt;
      cmd_q        <= cmd_nxt;
      loss_q       <= loss_nxt;
    end
  end

  // Next-state and output logic; relock overrides everything, including a word
  // that would otherwise be emitted on this boundary.
  always_comb begin
    sr_nxt         = {sr_q[WORD_W-2:0], fc.fc_in};
    ph_nxt         = ph_q + PH_W'(1);
    state_nxt      = state_q;
    cnt_nxt        = cnt_q;
    gap_nxt        = gap_q;
    word_nxt       = word_q;
    word_valid_nxt = 1'b0;
    word_idle_nxt  = word_idle_q;
    cmd_nxt        = cmd_q;
    loss_nxt       = loss_q;

    if (fc.relock) begin
      state_nxt = ST_SEARCH;
      cnt_nxt   = '0;
      gap_nxt   = '0;
      if (state_q == ST_LOCKED && loss_q != LOSS_SAT) begin
        loss_nxt = loss_q + LOSS_W'(1);
      end
    end else begin
      case (state_q)
        ST_SEARCH: begin
          // A match defines the word phase: this cycle becomes boundary zero.
          if (is_idle) begin
            ph_nxt    = PH_W'(1);
            cnt_nxt   = CNT_W'(1);
            state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (boundary) begin
            if (is_idle) begin
              cnt_nxt = cnt_inc;
              if (cnt_inc == LOCK_CNT) begin
                state_nxt = ST_LOCKED;
                gap_nxt   = '0;
              end
            end else begin
              state_nxt = ST_SEARCH;
              cnt_nxt   = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (boundary) begin
            word_nxt       = sr_q;
            word_idle_nxt  = is_idle;
            word_valid_nxt = 1'b1;
            if (is_idle) begin
              gap_nxt = '0;
            end else begin
              cmd_nxt = cmd_q + CMD_W'(1);
              gap_nxt = gap_inc;
              if (gap_inc == GAP_MAX) begin
                state_nxt = ST_SEARCH;
                gap_nxt   = '0;
                cnt_nxt   = '0;
                if (loss_q != LOSS_SAT) begin
                  loss_nxt = loss_q + LOSS_W'(1);
                end
              end
            end
          end
        end
        default: begin
          state_nxt = ST_SEARCH;
          cnt_nxt   = '0;
          gap_nxt   = '0;
        end
      endcase
    end

    locked_nxt = (state_nxt == ST_LOCKED);
  end

  assign fc.locked          = locked_q;
  assign fc.word_out        = word_q;
  assign fc.word_valid      = word_valid_q;
  assign fc.word_is_idle    = word_idle_q;
  assign fc.cmd_count       = cmd_q;
  assign fc.lock_loss_count = loss_q;

endmodule
